// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the returned word into the IF/ID register, with stall, redirect/squash and halt.
module if_stage #(
  parameter int unsigned IM_BYTES = 40,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] PCout,
  input  logic [31:0] IMout,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pcplus4,
  output logic        IFID_valid,
  output logic        done,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] IM_LIMIT = 32'(IM_BYTES);
  localparam logic [31:0] PC_INIT  = RESET_PC & ~32'd3;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = branch_target & ~32'd3;
  assign PCout          = pc;

  // Fetch halts once the PC leaves the image; IM reads beyond it are undefined.
  assign done = (pc >= IM_LIMIT);

  // Priority: reset, redirect (beats stall), stall, halted bubble, normal fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= PC_INIT;
      IFID_instr   <= 32'd0;
      IFID_pcplus4 <= 32'd0;
      IFID_valid   <= 1'b0;
      fetch_count  <= 16'd0;
    end else if (branch_taken) begin
      pc         <= target_aligned;
      IFID_instr <= 32'd0;
      IFID_valid <= 1'b0;
    end else if (stall) begin
      pc <= pc;
    end else if (done) begin
      IFID_instr <= 32'd0;
      IFID_valid <= 1'b0;
    end else begin
      pc           <= pc_plus4;
      IFID_instr   <= IMout;
      IFID_pcplus4 <= pc_plus4;
      IFID_valid   <= 1'b1;
      if (fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan scenarios, randomized
// stall/redirect/reset traffic against a behavioural model, and counter saturation.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] PCout;
  logic [31:0] IMout;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pcplus4;
  logic        IFID_valid;
  logic        done;
  logic [15:0] fetch_count;

  logic        big_rst_n;
  logic        big_stall;
  logic        big_branch;
  logic [31:0] big_target;
  logic [31:0] big_pc;
  logic [31:0] big_imout;
  logic [31:0] big_instr;
  logic [31:0] big_pcplus4;
  logic        big_valid;
  logic        big_done;
  logic [15:0] big_count;

  logic [31:0] rom [0:15];

  int total = 0;
  int bad   = 0;

  // Behavioural model of the visible IF/ID state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcp4;
  logic        m_valid;
  logic [15:0] m_count;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd40) return rom[a[5:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign IMout     = rom_word(PCout);
  assign big_imout = {big_pc[17:2], ~big_pc[17:2]};

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .PCout(PCout), .IMout(IMout),
    .IFID_instr(IFID_instr), .IFID_pcplus4(IFID_pcplus4), .IFID_valid(IFID_valid),
    .done(done), .fetch_count(fetch_count)
  );

  if_stage #(.IM_BYTES(32'h8_0000)) dut_big (
    .clk(clk), .rst_n(big_rst_n), .stall(big_stall), .branch_taken(big_branch),
    .branch_target(big_target), .PCout(big_pc), .IMout(big_imout),
    .IFID_instr(big_instr), .IFID_pcplus4(big_pcplus4), .IFID_valid(big_valid),
    .done(big_done), .fetch_count(big_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the given inputs; the model advances by the same edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst_n = r; stall = s; branch_taken = b; branch_target = t;
    if (!r) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0; m_count = 16'd0;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_instr = 32'd0; m_valid = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (m_pc >= 32'd40) begin
      m_instr = 32'd0; m_valid = 1'b0;
    end else begin
      m_instr = rom_word(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      if (m_count < 16'hFFFF) m_count = m_count + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (PCout !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", PCout); end
    total++; if (IFID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", IFID_valid); end
    total++; if (IFID_instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h want=0", IFID_instr); end
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%h want=0", fetch_count); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
    total++; if (IFID_instr !== 32'h00AA6820) begin bad++; $display("FAIL fetch3_instr got=%h want=00aa6820", IFID_instr); end
    total++; if (IFID_pcplus4 !== 32'd12) begin bad++; $display("FAIL fetch3_pcp4 got=%h want=c", IFID_pcplus4); end
    total++; if (PCout !== 32'd12) begin bad++; $display("FAIL fetch3_pc got=%h want=c", PCout); end
    total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL fetch3_count got=%h want=3", fetch_count); end
  endtask

  task automatic test_stall;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      total++; if (IFID_instr !== 32'h8C050000) begin bad++; $display("FAIL stall_instr[%0d] got=%h want=8c050000", i, IFID_instr); end
      total++; if (PCout !== 32'd4) begin bad++; $display("FAIL stall_pc[%0d] got=%h want=4", i, PCout); end
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    total++; if (IFID_instr !== 32'h8C0A0004) begin bad++; $display("FAIL post_stall_instr got=%h want=8c0a0004", IFID_instr); end
  endtask

  // Continues from test_stall with PC = 8 and two instructions accepted.
  task automatic test_redirect;
    step(1'b1, 1'b1, 1'b1, 32'h0000000E);
    total++; if (PCout !== 32'd12) begin bad++; $display("FAIL redir_pc got=%h want=c", PCout); end
    total++; if (IFID_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b want=0", IFID_valid); end
    total++; if (IFID_instr !== 32'd0) begin bad++; $display("FAIL redir_instr got=%h want=0", IFID_instr); end
    total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL redir_count got=%h want=2", fetch_count); end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    total++; if (IFID_pcplus4 !== 32'd16) begin bad++; $display("FAIL redir_next_pcp4 got=%h want=10", IFID_pcplus4); end
    total++; if (IFID_valid !== 1'b1) begin bad++; $display("FAIL redir_next_valid got=%b want=1", IFID_valid); end
    total++; if (IFID_instr !== rom[3]) begin bad++; $display("FAIL redir_next_instr got=%h want=%h", IFID_instr, rom[3]); end
  endtask

  task automatic test_end_of_program;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      total++; if (done !== (i == 10)) begin bad++; $display("FAIL eop_done[%0d] got=%b want=%b", i, done, (i == 10)); end
    end
    total++; if (PCout !== 32'd40) begin bad++; $display("FAIL eop_pc got=%h want=28", PCout); end
    total++; if (fetch_count !== 16'd10) begin bad++; $display("FAIL eop_count got=%h want=a", fetch_count); end
    total++; if (IFID_instr !== rom[9]) begin bad++; $display("FAIL eop_last_instr got=%h want=%h", IFID_instr, rom[9]); end
    for (int i = 11; i <= 13; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      total++; if (IFID_valid !== 1'b0) begin bad++; $display("FAIL eop_bubble[%0d] got=%b want=0", i, IFID_valid); end
      total++; if (PCout !== 32'd40) begin bad++; $display("FAIL eop_hold_pc[%0d] got=%h want=28", i, PCout); end
      total++; if (fetch_count !== 16'd10) begin bad++; $display("FAIL eop_hold_count[%0d] got=%h want=a", i, fetch_count); end
    end
    step(1'b1, 1'b0, 1'b1, 32'd0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL eop_restart_done got=%b want=0", done); end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    total++; if (IFID_instr !== 32'h8C050000) begin bad++; $display("FAIL eop_refetch got=%h want=8c050000", IFID_instr); end
    total++; if (IFID_valid !== 1'b1) begin bad++; $display("FAIL eop_refetch_valid got=%b want=1", IFID_valid); end
  endtask

  task automatic test_out_of_range;
    step(1'b1, 1'b0, 1'b1, 32'h100);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL oor_done got=%b want=1", done); end
    total++; if (PCout !== 32'h100) begin bad++; $display("FAIL oor_pc got=%h want=100", PCout); end
    step(1'b0, 1'b1, 1'b1, 32'h100);
    total++; if (PCout !== 32'd0) begin bad++; $display("FAIL rst_mid_pc got=%h want=0", PCout); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", done); end
    total++; if (IFID_instr !== 32'd0) begin bad++; $display("FAIL rst_mid_instr got=%h want=0", IFID_instr); end
    total++; if (IFID_pcplus4 !== 32'd0) begin bad++; $display("FAIL rst_mid_pcp4 got=%h want=0", IFID_pcplus4); end
    total++; if (IFID_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", IFID_valid); end
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%h want=0", fetch_count); end
  endtask

  task automatic test_random;
    logic r, s, b;
    logic [31:0] t;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 47));
      step(r, s, b, t);
      total++; if (PCout !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h want=%h", i, PCout, m_pc); end
      total++; if (done !== (m_pc >= 32'd40)) begin bad++; $display("FAIL rnd_done[%0d] got=%b want=%b", i, done, (m_pc >= 32'd40)); end
      total++; if (IFID_instr !== m_instr) begin bad++; $display("FAIL rnd_instr[%0d] got=%h want=%h", i, IFID_instr, m_instr); end
      total++; if (IFID_pcplus4 !== m_pcp4) begin bad++; $display("FAIL rnd_pcp4[%0d] got=%h want=%h", i, IFID_pcplus4, m_pcp4); end
      total++; if (IFID_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, IFID_valid, m_valid); end
      total++; if (fetch_count !== m_count) begin bad++; $display("FAIL rnd_count[%0d] got=%h want=%h", i, fetch_count, m_count); end
    end
  endtask

  // A large image lets 65534 uninterrupted fetches bring the counter to 0xFFFE.
  task automatic test_saturation;
    logic [31:0] p;
    big_rst_n = 1'b1;
    repeat (65534) begin
      @(posedge clk);
      #1;
    end
    total++; if (big_count !== 16'hFFFE) begin bad++; $display("FAIL sat_start got=%h want=fffe", big_count); end
    for (int i = 0; i < 3; i++) begin
      p = 32'd4 * (32'd65534 + 32'(i));
      @(posedge clk);
      #1;
      total++; if (big_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count[%0d] got=%h want=ffff", i, big_count); end
      total++; if (big_instr !== {p[17:2], ~p[17:2]}) begin bad++; $display("FAIL sat_instr[%0d] got=%h want=%h", i, big_instr, {p[17:2], ~p[17:2]}); end
      total++; if (big_pc !== p + 32'd4) begin bad++; $display("FAIL sat_pc[%0d] got=%h want=%h", i, big_pc, p + 32'd4); end
    end
  endtask

  initial begin
    rom[0] = 32'h8C050000;
    rom[1] = 32'h8C0A0004;
    rom[2] = 32'h00AA6820;
    for (int i = 3; i < 16; i++) rom[i] = $urandom;
    m_pc = 32'd0; m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0; m_count = 16'd0;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    big_rst_n = 1'b0; big_stall = 1'b0; big_branch = 1'b0; big_target = 32'd0;
    #1;
    test_reset;
    test_stall;
    test_redirect;
    test_end_of_program;
    test_out_of_range;
    test_random;
    test_saturation;
    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
